// File: rtl/mantissa_addsub_pipe.sv
// Two-stage sign-magnitude mantissa adder/subtractor with valid/ready handshake.
// Stage 1 orders the operands by magnitude; stage 2 adds/subtracts and counts leading zeros.
module mantissa_addsub_pipe #(
  parameter  int MANTISSA_WIDTH = 23,
  parameter  int TAG_WIDTH      = 4,
  localparam int W              = MANTISSA_WIDTH + 4,
  localparam int LZW            = $clog2(W + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         man_a,
  input  logic [W-1:0]         man_b,
  input  logic                 sign_a,
  input  logic                 sign_b,
  input  logic                 sub_op,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         mag,
  output logic                 carry_out,
  output logic                 sign_r,
  output logic                 zero,
  output logic [LZW-1:0]       lzc,
  output logic [TAG_WIDTH-1:0] out_tag
);

  logic s1_valid_q, s2_valid_q;
  logic s1_adv, s2_adv;

  assign s2_adv    = !s2_valid_q || out_ready;
  assign s1_adv    = !s1_valid_q || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      if (s2_adv) s2_valid_q <= s1_valid_q;
      if (s1_adv) s1_valid_q <= in_valid;
    end
  end

  // Stage 1: order operands so stage 2 never subtracts into a negative value.
  logic           a_ge_b_d;
  logic [W-1:0]   big_d, small_d;
  logic [W-1:0]   big_q, small_q;
  logic           a_ge_b_q, eff_sub_q, sign_a_q, sign_b_q, sub_op_q;
  logic [TAG_WIDTH-1:0] tag1_q;

  assign a_ge_b_d = (man_a >= man_b);
  assign big_d    = a_ge_b_d ? man_a : man_b;
  assign small_d  = a_ge_b_d ? man_b : man_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      big_q     <= '0;
      small_q   <= '0;
      a_ge_b_q  <= 1'b0;
      eff_sub_q <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      sub_op_q  <= 1'b0;
      tag1_q    <= '0;
    end else if (s1_adv && in_valid) begin
      big_q     <= big_d;
      small_q   <= small_d;
      a_ge_b_q  <= a_ge_b_d;
      eff_sub_q <= sub_op ^ sign_a ^ sign_b;
      sign_a_q  <= sign_a;
      sign_b_q  <= sign_b;
      sub_op_q  <= sub_op;
      tag1_q    <= in_tag;
    end
  end

  // Stage 2: magnitude arithmetic, sign resolution and leading-zero count.
  logic [W:0]     res_d;
  logic [W-1:0]   mag_d;
  logic           sign_d, zero_d;
  logic [LZW-1:0] lzc_d;

  always_comb begin
    res_d = eff_sub_q ? {1'b0, big_q - small_q} : ({1'b0, big_q} + {1'b0, small_q});
    mag_d = res_d[W-1:0];
    zero_d = (mag_d == '0);
    // Exact cancellation yields +0; an effective add keeps A's sign even for -0 + -0.
    if (!eff_sub_q)     sign_d = sign_a_q;
    else if (zero_d)    sign_d = 1'b0;
    else if (a_ge_b_q)  sign_d = sign_a_q;
    else                sign_d = sign_b_q ^ sub_op_q;
    lzc_d = LZW'(W);
    for (int i = 0; i < W; i++)
      if (mag_d[i]) lzc_d = LZW'(W - 1 - i);
  end

  logic [W-1:0]         mag_q;
  logic                 carry_q, sign_q, zero_q;
  logic [LZW-1:0]       lzc_q;
  logic [TAG_WIDTH-1:0] tag2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q   <= '0;
      carry_q <= 1'b0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      lzc_q   <= '0;
      tag2_q  <= '0;
    end else if (s2_adv && s1_valid_q) begin
      mag_q   <= mag_d;
      carry_q <= res_d[W];
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      lzc_q   <= lzc_d;
      tag2_q  <= tag1_q;
    end
  end

  assign mag       = mag_q;
  assign carry_out = carry_q;
  assign sign_r    = sign_q;
  assign zero      = zero_q;
  assign lzc       = lzc_q;
  assign out_tag   = tag2_q;

endmodule

// File: tb/tb_mantissa_addsub_pipe.sv
// Scoreboard bench: signed-integer reference model, directed cases, backpressure, flush, reset, random.
module tb_mantissa_addsub_pipe;
  localparam int MW  = 4;
  localparam int TW  = 4;
  localparam int W   = MW + 4;
  localparam int LZW = $clog2(W + 1);

  typedef struct packed {
    logic [W-1:0]   mag;
    logic           c;
    logic           s;
    logic           z;
    logic [LZW-1:0] lzc;
    logic [TW-1:0]  tag;
  } res_t;

  logic clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] man_a, man_b, mag;
  logic sign_a, sign_b, sub_op, carry_out, sign_r, zero;
  logic [TW-1:0] in_tag, out_tag;
  logic [LZW-1:0] lzc;

  int checks = 0;
  int failures = 0;
  res_t expq[$];

  mantissa_addsub_pipe #(.MANTISSA_WIDTH(MW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .man_a(man_a), .man_b(man_b), .sign_a(sign_a), .sign_b(sign_b), .sub_op(sub_op),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .mag(mag),
    .carry_out(carry_out), .sign_r(sign_r), .zero(zero), .lzc(lzc), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: treat operands as signed integers and take |A op B|.
  function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b, logic sa, logic sb,
                                 logic op, logic [TW-1:0] t);
    res_t e;
    int va, vb, r, m;
    va = sa ? -int'(a) : int'(a);
    vb = (sb ^ op) ? -int'(b) : int'(b);
    r  = va + vb;
    m  = (r < 0) ? -r : r;
    e.mag = m[W-1:0];
    e.c   = m[W];
    e.z   = (e.mag == 0);
    e.lzc = LZW'(W - $clog2(int'(e.mag) + 1));
    if (r < 0)      e.s = 1'b1;
    else if (r > 0) e.s = 1'b0;
    else            e.s = (sa == (sb ^ op)) ? sa : 1'b0;
    e.tag = t;
    return e;
  endfunction

  always @(negedge clk)
    if (rst_n && !flush && in_valid && in_ready)
      expq.push_back(model(man_a, man_b, sign_a, sign_b, sub_op, in_tag));

  res_t cur, held;
  bit stalled = 0;
  always @(negedge clk) begin
    cur = '{mag: mag, c: carry_out, s: sign_r, z: zero, lzc: lzc, tag: out_tag};
    if (rst_n && out_valid) begin
      if (stalled) chk("hold_stable", 32'(cur), 32'(held));
      if (out_ready) begin
        if (expq.size() == 0) begin
          checks++; failures++;
          $display("FAIL scoreboard: unexpected output tag=%0h mag=%0h", out_tag, mag);
        end else begin
          res_t e;
          e = expq.pop_front();
          checks++;
          if (cur !== e) begin
            failures++;
            $display("FAIL scoreboard: got mag=%0h c=%0b s=%0b z=%0b lzc=%0d tag=%0h expected mag=%0h c=%0b s=%0b z=%0b lzc=%0d tag=%0h",
                     cur.mag, cur.c, cur.s, cur.z, cur.lzc, cur.tag, e.mag, e.c, e.s, e.z, e.lzc, e.tag);
          end
        end
        stalled = 0;
      end else stalled = 1;
      held = cur;
    end else stalled = 0;
  end

  task automatic directed(string nm, logic [W-1:0] a, logic [W-1:0] b, logic sa, logic sb,
                          logic op, logic [TW-1:0] t, logic [W-1:0] em, logic ec, logic es,
                          logic ez, logic [LZW-1:0] el);
    int lat;
    out_ready = 1; man_a = a; man_b = b; sign_a = sa; sign_b = sb; sub_op = op; in_tag = t;
    in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 10) begin @(negedge clk); lat++; end
    chk({nm, "_latency"}, lat, 2);
    chk({nm, "_mag"}, mag, em);
    chk({nm, "_flags"}, {carry_out, sign_r, zero}, {ec, es, ez});
    chk({nm, "_lzc"}, lzc, el);
    chk({nm, "_tag"}, out_tag, t);
    @(posedge clk); #1;
  endtask

  task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic sa, logic sb, logic op,
                      logic [TW-1:0] t);
    int cnt;
    man_a = a; man_b = b; sign_a = sa; sign_b = sb; sub_op = op; in_tag = t; in_valid = 1;
    cnt = 0;
    @(negedge clk);
    while (!in_ready && cnt < 50) begin @(negedge clk); cnt++; end
    if (cnt >= 50) chk("accept_timeout", 1, 0);
    @(posedge clk); #1 in_valid = 0;
  endtask

  initial begin
    int sent, cyc, cnt;
    bit acc;
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 0;
    man_a = 0; man_b = 0; sign_a = 0; sign_b = 0; sub_op = 0; in_tag = 0;
    #3 chk("rst_out_valid", out_valid, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid_rel", out_valid, 0);
    chk("rst_data", {mag, carry_out, sign_r, zero, lzc, out_tag}, 0);
    @(posedge clk); #1;

    directed("add",      8'h40, 8'h20, 0, 0, 0, 4'h1, 8'h60, 0, 0, 0, 4'd1);
    directed("add_ovf",  8'hF0, 8'h20, 0, 0, 0, 4'h2, 8'h10, 1, 0, 0, 4'd3);
    directed("neg_add",  8'h40, 8'h20, 1, 1, 1, 4'h3, 8'h20, 0, 1, 0, 4'd2);
    directed("sub_blt",  8'h20, 8'h40, 0, 0, 1, 4'h4, 8'h20, 0, 1, 0, 4'd2);
    directed("sgn_sub",  8'h20, 8'h40, 0, 1, 0, 4'h5, 8'h20, 0, 1, 0, 4'd2);
    directed("cancel",   8'h5C, 8'h5C, 0, 0, 1, 4'h6, 8'h00, 0, 0, 1, 4'd8);
    directed("negzero",  8'h00, 8'h00, 1, 1, 0, 4'h7, 8'h00, 0, 1, 1, 4'd8);
    directed("sub_agt",  8'h40, 8'h20, 1, 0, 0, 4'h8, 8'h20, 0, 1, 0, 4'd2);

    // Backpressure: two fill the pipe, third waits; outputs must hold tag 1.
    out_ready = 0;
    fork
      begin
        send(8'h11, 8'h22, 0, 0, 0, 4'h1);
        send(8'h33, 8'h44, 0, 1, 0, 4'h2);
        send(8'h55, 8'h66, 1, 0, 1, 4'h3);
      end
      begin
        repeat (3) @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
          chk("bp_hold_tag", {out_valid, out_tag}, {1'b1, 4'h1});
          @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1;
        for (int k = 1; k <= 3; k++) begin
          @(negedge clk);
          chk("bp_order", {out_valid, out_tag}, {1'b1, 4'(k)});
        end
      end
    join
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;

    // Flush with two in flight.
    out_ready = 0;
    send(8'h12, 8'h34, 0, 0, 0, 4'h5);
    send(8'h56, 8'h78, 0, 0, 1, 4'h6);
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    @(posedge clk); #1 flush = 1; in_valid = 1; in_tag = 4'h7;
    @(posedge clk); #1 flush = 0; in_valid = 0;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    expq.delete();
    out_ready = 1;
    repeat (4) begin @(negedge clk); chk("flush_no_out", out_valid, 0); end
    @(posedge clk); #1;

    // Async reset with two in flight.
    out_ready = 0;
    send(8'h9A, 8'h0B, 1, 0, 0, 4'h8);
    send(8'h0C, 8'h7D, 0, 0, 1, 4'h9);
    chk("rst_pre_valid", out_valid, 1);
    #1 rst_n = 0;
    #1 chk("rst_async_drop", out_valid, 0);
    expq.delete();
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Random traffic with random backpressure.
    sent = 0; cyc = 0;
    while (sent < 400 && cyc < 20000) begin
      @(negedge clk); acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin in_valid = 0; sent++; end
      out_ready = ($urandom % 4) != 0;
      if (!in_valid && sent < 400 && ($urandom % 4) != 0) begin
        man_a  = W'($urandom);
        man_b  = (($urandom % 8) == 0) ? man_a : W'($urandom);
        sign_a = 1'($urandom); sign_b = 1'($urandom); sub_op = 1'($urandom);
        in_tag = TW'($urandom);
        in_valid = 1;
      end
      cyc++;
    end
    chk("rand_all_sent", sent, 400);
    out_ready = 1;
    cnt = 0;
    while (expq.size() != 0 && cnt < 100) begin @(negedge clk); cnt++; end
    chk("drain_empty", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
